detector_sequencer: RTL and testbench
=====================================

Name: detector_sequencer

Overview:
Controller that sequences the 01[0*]1 sequence_detector from a parallel test word. It accepts a WORD_W-bit word over a valid/ready handshake and pulses the detector's active-high clear. It then streams the word serially, one bit per clock with enable asserted, counts detector flag (z) assertions, and reports completion with a match count. It sits between a host/register interface and the detector instance.

Parameters:
WORD_W, 24, bits per test word; bit 0 is streamed first.
CNT_W, 5, match counter width; must be >= 1.
CLR_CYCLES, 1, cycles det_clr is held high before streaming; must be >= 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
word_in  input  WORD_W  test word; word_in[0] is sent first.
word_valid  input  1  word_in valid.
word_ready  output  1  high only in IDLE.
abort  input  1  cancels an operation in progress.
det_clr  output  1  active-high clear to the detector's rst.
det_ena  output  1  detector enable.
det_sig  output  1  serial bit to the detector's sig_to_test.
det_z  input  1  detector sequence flag (Mealy; valid in the same cycle as det_sig).
busy  output  1  high in CLEAR, STREAM and DONE.
done  output  1  one-cycle completion pulse.
match_cnt  output  CNT_W  number of z hits in the last or current run.

Behaviour:
- All outputs are registered.
- Reset values (rst low, asynchronous): state=IDLE, word_ready=1, det_clr=1 (holds the detector cleared), det_ena=0, det_sig=0, busy=0, done=0, match_cnt=0.
- On the first clk edge after reset release, det_clr drops to 0.
- States: IDLE, CLEAR, STREAM, DONE.
- IDLE:
  - On word_valid&&word_ready: latch word_in into the serializer, clear match_cnt to 0, go to CLEAR.
  - word_valid is ignored in every other state.
- CLEAR:
  - det_clr=1, det_ena=0 for exactly CLR_CYCLES cycles, then go to STREAM.
- STREAM:
  - Lasts exactly WORD_W cycles, k=0..WORD_W-1.
  - In cycle k: det_sig=word[k], det_ena=1, det_clr=0.
  - If det_z=1 in cycle k, match_cnt increments at the end of that cycle, saturating at 2^CNT_W-1.
  - After cycle WORD_W-1, go to DONE.
- DONE:
  - done=1, det_ena=0, det_sig=0 for one cycle, then return to IDLE.
  - match_cnt holds until the next accept.
- Latency: the handshake occurs at edge E. det_clr is high for cycles E+1..E+CLR_CYCLES. The stream occupies the next WORD_W cycles. done is high in cycle E+CLR_CYCLES+WORD_W+1. The next accept is possible one cycle later.
- det_z is ignored whenever det_ena=0.
- abort=1 in CLEAR or STREAM:
  - Go to IDLE at the next edge; det_ena=0, no done pulse.
  - match_cnt holds its partial value.
- abort in IDLE or DONE: no effect.
- Reset asserted mid-operation: immediate return to reset values; the partial count is lost.

Optional Feature:
DETECTOR_SEQ_FIRST_HIT_EN.
- Defined: adds outputs first_hit_vld (1 bit) and first_hit_idx ($clog2(WORD_W) bits).
  - Both are cleared on accept.
  - On the first det_z in STREAM cycle k: first_hit_idx=k, first_hit_vld=1.
  - Both hold until the next accept. Reset value of both is 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package detector_seq_pkg: state enum seq_state_t {IDLE, CLEAR, STREAM, DONE}; default constants for WORD_W, CNT_W, CLR_CYCLES.
- One sub-module, word_serializer: parallel load plus a right-shift register.
  - Bit 0 drives det_sig.
  - The serializer also provides the k index counter and a last-bit flag.

Test Plan:
- Reset mid-STREAM (k=5): rst low -> immediately det_clr=1, det_ena=0, busy=0, match_cnt=0, word_ready=1. Release -> det_clr=0 after one edge.
- Streaming: word_in=24'hCA_A5_13, CLR_CYCLES=1 ->
  - det_clr high 1 cycle, then det_sig equals word_in[k] for k=0..23 with det_ena high exactly 24 cycles.
  - done in cycle E+26.
- Counting with det_z stub high at k=3, 7, 20 -> match_cnt=3 at done. With DETECTOR_SEQ_FIRST_HIT_EN: first_hit_idx=3, first_hit_vld=1.
- det_z held high during IDLE, CLEAR and DONE only -> match_cnt=0, first_hit_vld=0.
- CNT_W=2, det_z high for all 24 STREAM cycles -> match_cnt=3 (saturated), no wrap.
- abort at k=10 with z hit at k=3 ->
  - IDLE next cycle, no done pulse, match_cnt=1.
  - word_valid held high -> new word accepted on that IDLE cycle and match_cnt clears to 0.

Source files
------------

// File: rtl/detector_seq_pkg.sv
// Shared types and defaults for the detector sequencer and its serializer.
package detector_seq_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} seq_state_t;

  localparam int DEF_WORD_W     = 24;
  localparam int DEF_CNT_W      = 5;
  localparam int DEF_CLR_CYCLES = 1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/detector_sequencer_word_serializer.sv
// Parallel-load, right-shift serializer with bit index and last-bit flag.
module word_serializer
  import detector_seq_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int IDX_W  = idx_width(DEF_WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic              flush,
  input  logic [WORD_W-1:0] word_in,
  output logic              bit_out,
  output logic [IDX_W-1:0]  idx,
  output logic              last
);

  // An extra zero sits below the word so the output stays low until the
  // first shift presents bit 0; zeros fill in from the top afterwards.
  logic [WORD_W:0] sreg;
  logic            active;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg   <= '0;
      idx    <= '0;
      active <= 1'b0;
    end else if (load) begin
      sreg   <= {word_in, 1'b0};
      idx    <= '0;
      active <= 1'b0;
    end else if (flush) begin
      sreg   <= '0;
      idx    <= '0;
      active <= 1'b0;
    end else if (shift) begin
      sreg   <= {1'b0, sreg[WORD_W:1]};
      active <= 1'b1;
      if (active) idx <= idx + IDX_W'(1);
    end
  end

  assign bit_out = sreg[0];
  assign last    = active && (idx == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/detector_sequencer.sv
// Sequences a 01[0*]1 detector from a parallel test word and counts its hits.
// Optional first-hit reporting is enabled by defining DETECTOR_SEQ_FIRST_HIT_EN.
module detector_sequencer
  import detector_seq_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int CLR_CYCLES = DEF_CLR_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic              abort,
  output logic              det_clr,
  output logic              det_ena,
  output logic              det_sig,
  input  logic              det_z,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt
`ifdef DETECTOR_SEQ_FIRST_HIT_EN
  ,
  output logic                           first_hit_vld,
  output logic [idx_width(WORD_W)-1:0]   first_hit_idx
`endif
);

  localparam int IDX_W = idx_width(WORD_W);
  localparam int CLR_W = idx_width(CLR_CYCLES);

  seq_state_t       state, next_state;
  logic [CLR_W-1:0] clr_cnt;
  logic             accept, clr_done;
  logic             ser_shift, ser_flush, ser_last;
  logic [IDX_W-1:0] ser_idx;
  logic             word_ready_d, det_clr_d, det_ena_d, busy_d, done_d;

  assign accept   = (state == IDLE) && word_valid;
  assign clr_done = (clr_cnt == CLR_W'(CLR_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (word_valid) next_state = CLEAR;
      CLEAR:   if (abort) next_state = IDLE;
               else if (clr_done) next_state = STREAM;
      STREAM:  if (abort) next_state = IDLE;
               else if (ser_last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every output is a flop.
  always_comb begin
    word_ready_d = (next_state == IDLE);
    det_clr_d    = (next_state == CLEAR);
    det_ena_d    = (next_state == STREAM);
    busy_d       = (next_state != IDLE);
    done_d       = (next_state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_ready <= 1'b1;
      det_clr    <= 1'b1;
      det_ena    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      word_ready <= word_ready_d;
      det_clr    <= det_clr_d;
      det_ena    <= det_ena_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_cnt   <= '0;
      match_cnt <= '0;
    end else begin
      if (accept) clr_cnt <= '0;
      else if (state == CLEAR) clr_cnt <= clr_cnt + CLR_W'(1);

      if (accept) match_cnt <= '0;
      else if (det_ena && det_z && (match_cnt != '1)) match_cnt <= match_cnt + CNT_W'(1);
    end
  end

  // The serializer register itself is det_sig; it is zeroed outside STREAM.
  assign ser_shift = (next_state == STREAM);
  assign ser_flush = (next_state == IDLE) || (next_state == DONE);

  word_serializer #(
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_serializer (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .shift   (ser_shift),
    .flush   (ser_flush),
    .word_in (word_in),
    .bit_out (det_sig),
    .idx     (ser_idx),
    .last    (ser_last)
  );

`ifdef DETECTOR_SEQ_FIRST_HIT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_hit_vld <= 1'b0;
      first_hit_idx <= '0;
    end else if (accept) begin
      first_hit_vld <= 1'b0;
      first_hit_idx <= '0;
    end else if (det_ena && det_z && !first_hit_vld) begin
      first_hit_vld <= 1'b1;
      first_hit_idx <= ser_idx;
    end
  end
`else
  logic unused_ser_idx;
  assign unused_ser_idx = ^ser_idx;
`endif

endmodule

// File: tb/tb_detector_sequencer.sv
// Scoreboard bench for detector_sequencer: random words and detector flags
// checked against a bit-counting reference model.
module tb_detector_sequencer;
  import detector_seq_pkg::*;

  localparam int WORD_W     = 24;
  localparam int CNT_W      = 5;
  localparam int SAT_CNT_W  = 2;
  localparam int CLR_CYCLES = 1;
  localparam int IDX_W      = idx_width(WORD_W);

  typedef struct {
    logic [WORD_W-1:0] word;
    bit                aborted;
    int                cnt;
    int                sat_cnt;
    bit                fh_vld;
    int                fh_idx;
    int                ena_cycles;
    int                clr_cycles;
    int                end_cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [WORD_W-1:0] word_in = '0;
  logic              word_valid = 1'b0;
  logic              abort = 1'b0;
  logic              det_z = 1'b0;

  logic                 word_ready, det_clr, det_ena, det_sig, busy, done;
  logic [CNT_W-1:0]     match_cnt;
  logic                 s_word_ready, s_det_clr, s_det_ena, s_det_sig, s_busy, s_done;
  logic [SAT_CNT_W-1:0] s_match_cnt;
`ifdef DETECTOR_SEQ_FIRST_HIT_EN
  logic                 first_hit_vld, s_first_hit_vld;
  logic [IDX_W-1:0]     first_hit_idx, s_first_hit_idx;
`endif

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  detector_sequencer #(.WORD_W(WORD_W), .CNT_W(CNT_W), .CLR_CYCLES(CLR_CYCLES)) dut (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .abort(abort), .det_clr(det_clr), .det_ena(det_ena),
    .det_sig(det_sig), .det_z(det_z), .busy(busy), .done(done), .match_cnt(match_cnt)
`ifdef DETECTOR_SEQ_FIRST_HIT_EN
    , .first_hit_vld(first_hit_vld), .first_hit_idx(first_hit_idx)
`endif
  );

  detector_sequencer #(.WORD_W(WORD_W), .CNT_W(SAT_CNT_W), .CLR_CYCLES(CLR_CYCLES)) dut_sat (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
    .word_ready(s_word_ready), .abort(abort), .det_clr(s_det_clr), .det_ena(s_det_ena),
    .det_sig(s_det_sig), .det_z(det_z), .busy(s_busy), .done(s_done), .match_cnt(s_match_cnt)
`ifdef DETECTOR_SEQ_FIRST_HIT_EN
    , .first_hit_vld(s_first_hit_vld), .first_hit_idx(s_first_hit_idx)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference model: hits are simply the set z bits among the streamed positions.
  function automatic exp_t model(input logic [WORD_W-1:0] w, input logic [WORD_W-1:0] zmask,
                                 input int abort_at, input int acc);
    exp_t e;
    int   hits = 0;
    e.word = w;
    e.aborted = (abort_at != -1);
    e.ena_cycles = (abort_at == -1) ? WORD_W : ((abort_at == -2) ? 0 : abort_at + 1);
    e.clr_cycles = (abort_at == -2) ? 1 : CLR_CYCLES;
    e.fh_vld = 1'b0;
    e.fh_idx = 0;
    for (int k = 0; k < e.ena_cycles; k++) begin
      if (zmask[k]) begin
        hits++;
        if (!e.fh_vld) begin
          e.fh_vld = 1'b1;
          e.fh_idx = k;
        end
      end
    end
    e.cnt = min_int(hits, (1 << CNT_W) - 1);
    e.sat_cnt = min_int(hits, (1 << SAT_CNT_W) - 1);
    if (abort_at == -1)      e.end_cyc = acc + CLR_CYCLES + WORD_W;
    else if (abort_at == -2) e.end_cyc = acc + 1;
    else                     e.end_cyc = acc + CLR_CYCLES + abort_at + 1;
    return e;
  endfunction

  task automatic waitReady();
    int guard = 0;
    while (word_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) checkOutput("ready_timeout", {31'd0, word_ready}, 32'd1);
  endtask

  // abort_at: -1 none, -2 first CLEAR cycle, k>=0 STREAM cycle k.
  task automatic applyStimulus(input logic [WORD_W-1:0] w, input logic [WORD_W-1:0] zmask,
                               input bit z_out, input int abort_at, input bit hold_valid);
    int acc;
    waitReady();
    word_in = w;
    word_valid = 1'b1;
    det_z = z_out;
    abort = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    word_valid = 1'b0;
    acc = cyc;
    sb.push_back(model(w, zmask, abort_at, acc));
    for (int c = 0; c < CLR_CYCLES; c++) begin
      det_z = z_out;
      abort = (abort_at == -2 && c == 0);
      if (abort) begin
        word_valid = hold_valid;
        word_in = WORD_W'($urandom);
      end
      @(posedge clk); #1;
      abort = 1'b0;
      if (abort_at == -2) begin
        if (!hold_valid) word_valid = 1'b0;
        return;
      end
    end
    for (int k = 0; k < WORD_W; k++) begin
      det_z = zmask[k];
      abort = (k == abort_at);
      if (abort) begin
        word_valid = hold_valid;
        word_in = WORD_W'($urandom);
      end
      @(posedge clk); #1;
      abort = 1'b0;
      if (k == abort_at) begin
        if (!hold_valid) word_valid = 1'b0;
        det_z = 1'b0;
        return;
      end
    end
    det_z = z_out;
    abort = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    abort = 1'b0;
    det_z = 1'b0;
  endtask

  task automatic idleGap(input int n);
    repeat (n) begin
      det_z = 1'($urandom_range(0, 1));
      abort = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    det_z = 1'b0;
    abort = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_word_ready"}, {31'd0, word_ready}, 32'd1);
    checkOutput({tag, "_det_clr"}, {31'd0, det_clr}, 32'd1);
    checkOutput({tag, "_det_ena"}, {31'd0, det_ena}, 32'd0);
    checkOutput({tag, "_det_sig"}, {31'd0, det_sig}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_match_cnt"}, 32'(match_cnt), 32'd0);
    checkOutput({tag, "_sat_match_cnt"}, 32'(s_match_cnt), 32'd0);
`ifdef DETECTOR_SEQ_FIRST_HIT_EN
    checkOutput({tag, "_first_hit_vld"}, {31'd0, first_hit_vld}, 32'd0);
    checkOutput({tag, "_first_hit_idx"}, 32'(first_hit_idx), 32'd0);
`endif
  endtask

  task automatic releaseReset(input string tag);
    @(negedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, "_clr_drop"}, {31'd0, det_clr}, 32'd0);
    checkOutput({tag, "_ready_after"}, {31'd0, word_ready}, 32'd1);
  endtask

  // Reset lands in STREAM cycle 5 with det_z high so the lost count is visible.
  task automatic applyResetMidStream(input logic [WORD_W-1:0] w);
    waitReady();
    word_in = w;
    word_valid = 1'b1;
    @(posedge clk); #1;
    word_valid = 1'b0;
    sb.push_back(model(w, '0, -1, cyc));
    det_z = 1'b1;
    repeat (CLR_CYCLES + 5) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    checkResetValues("midreset");
    det_z = 1'b0;
    releaseReset("midreset");
  endtask

  // Monitor: per-cycle stream checks, plus a scoreboard pop at every run end.
  bit prev_busy = 1'b0, prev_done = 1'b0;
  int clr_run = 0, ena_run = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_busy = 1'b0;
      prev_done = 1'b0;
      clr_run = 0;
      ena_run = 0;
    end else begin
      if (det_clr) begin
        clr_run++;
        checkOutput("clear_match_cnt", 32'(match_cnt), 32'd0);
`ifdef DETECTOR_SEQ_FIRST_HIT_EN
        checkOutput("clear_first_hit_vld", {31'd0, first_hit_vld}, 32'd0);
`endif
      end
      if (det_ena) begin
        if (sb.size() == 0 || ena_run >= WORD_W) begin
          checkOutput("unexpected_stream", {31'd0, det_ena}, 32'd0);
        end else begin
          checkOutput("det_sig", {31'd0, det_sig}, {31'd0, sb[0].word[ena_run]});
        end
        ena_run++;
      end
      if (done || (prev_busy && !busy && !prev_done)) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_end", {31'd0, done}, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("end_is_abort", {31'd0, !done}, {31'd0, e.aborted});
          checkOutput("end_cycle", 32'(cyc), 32'(e.end_cyc));
          checkOutput("end_busy", {31'd0, busy}, {31'd0, !e.aborted});
          checkOutput("end_det_ena", {31'd0, det_ena}, 32'd0);
          checkOutput("end_det_sig", {31'd0, det_sig}, 32'd0);
          checkOutput("clr_cycles", 32'(clr_run), 32'(e.clr_cycles));
          checkOutput("ena_cycles", 32'(ena_run), 32'(e.ena_cycles));
          checkOutput("match_cnt", 32'(match_cnt), 32'(e.cnt));
          checkOutput("sat_match_cnt", 32'(s_match_cnt), 32'(e.sat_cnt));
`ifdef DETECTOR_SEQ_FIRST_HIT_EN
          checkOutput("first_hit_vld", {31'd0, first_hit_vld}, {31'd0, e.fh_vld});
          if (e.fh_vld) checkOutput("first_hit_idx", 32'(first_hit_idx), 32'(e.fh_idx));
`endif
        end
        clr_run = 0;
        ena_run = 0;
      end
      prev_busy = busy;
      prev_done = done;
    end
  end

  initial begin
    #200000;
    checkOutput("watchdog", 32'd1, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [WORD_W-1:0] w, zm;
    int ab, r, guard;
    bit zo, hv;

    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    releaseReset("reset");

    applyStimulus(24'hCAA513, 24'h000000, 1'b0, -1, 1'b0);
    idleGap(2);
    applyStimulus(24'hCAA513, 24'h100088, 1'b0, -1, 1'b0);
    applyStimulus(24'h5A5A5A, 24'h000000, 1'b1, -1, 1'b0);
    idleGap(1);
    applyStimulus(24'h0F0F0F, 24'hFFFFFF, 1'b0, -1, 1'b0);
    applyStimulus(24'h123456, 24'h100088, 1'b0, 10, 1'b1);
    applyStimulus(24'h654321, 24'h000410, 1'b1, -1, 1'b0);
    applyStimulus(24'hABCDEF, 24'hFFFFFF, 1'b1, -2, 1'b0);
    idleGap(2);
    applyResetMidStream(24'hFFFFFF);

    for (int i = 0; i < 25; i++) begin
      w  = WORD_W'($urandom);
      zm = WORD_W'($urandom & $urandom);
      zo = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      ab = (r < 6) ? -1 : ((r < 8) ? int'($urandom_range(0, WORD_W - 1)) : -2);
      hv = (ab != -1) && ($urandom_range(0, 1) == 1);
      applyStimulus(w, zm, zo, ab, hv);
      if (!hv) idleGap(int'($urandom_range(0, 3)));
    end
    applyStimulus(24'hC3C3C3, WORD_W'($urandom), 1'b1, -1, 1'b0);

    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
